reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Shares one register-bank access port (the write/read port of the RW_REG/RO_REG bank behind the bridge) among NUM_REQ requesters, e.g. the software bridge plus hardware masters.
- Arbitrates round-robin, sequences each access through a 3-state FSM, and returns read data with a one-cycle ACK to the winner.
- Sits between the bus-bridge/master side and the register bank's address decoder.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 8, register word address width.
- DATA_WIDTH, 32, register data width.

Ports:
- CLK  in  1  clock; everything is rising-edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NUM_REQ  per-requester request level.
- REQ_WEN  in  NUM_REQ  per-requester write (1) / read (0).
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_WDATA  in  NUM_REQ*DATA_WIDTH  packed write data, same packing rule.
- GNT  out  NUM_REQ  one-hot; the current owner, held ACCESS through RESP.
- ACK  out  NUM_REQ  one-hot, 1-cycle pulse; the access has completed.
- RDATA  out  DATA_WIDTH  read data; valid in the ACK cycle and held until the next ACK.
- REG_WEN  out  1  bank write strobe.
- REG_REN  out  1  bank read strobe.
- REG_ADDR  out  ADDR_WIDTH  bank address.
- REG_WDATA  out  DATA_WIDTH  bank write data.
- REG_RDATA  in  DATA_WIDTH  bank read data; valid one cycle after REG_REN.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State = IDLE; RR pointer = 0.
  - GNT, ACK, REG_WEN, REG_REN, REG_ADDR, REG_WDATA and RDATA = 0.
  - An in-flight access is dropped with no ACK.
- IDLE:
  - If REQ != 0, pick the winner: the first set bit of REQ searching from the RR pointer upward, with wrap-around.
  - Register GNT, the winner's address, data and WEN; go to ACCESS.
  - If REQ == 0, stay in IDLE.
- ACCESS (1 cycle):
  - Drive REG_ADDR and REG_WDATA from the captured values.
  - Assert exactly one of REG_WEN or REG_REN for this single cycle.
  - RR pointer = (winner+1) mod NUM_REQ.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse ACK[winner].
  - On a read, RDATA <= REG_RDATA; on a write, RDATA is unchanged.
  - Clear GNT at exit; go to IDLE.
- Latency and throughput:
  - REQ sampled in IDLE at cycle N -> strobe at N+1 -> ACK at N+2.
  - One access per 3 cycles at most.
  - Back-to-back REQ from the same requester is re-arbitrated on each pass.
- Handshake:
  - A requester holds REQ, REQ_WEN, REQ_ADDR and REQ_WDATA until its ACK, then may drop or re-raise REQ.
  - Changes after the IDLE sample are ignored, because the values are captured.
  - REQ dropped before ACK: the access still completes and ACK still pulses.
- Simultaneous requests: only one is granted per pass. Losers keep REQ high and are served in RR order; there is no starvation (worst-case wait is (NUM_REQ-1)*3 cycles).
- REG_ADDR and REG_WDATA hold their last value outside ACCESS; the strobes are 0 outside ACCESS.

Optional Feature:
- Macro: REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest index wins. The RR pointer is removed, and a persistent REQ[0] starves the others.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package reg_arb_pkg:
  - State enum arb_state_t {IDLE, ACCESS, RESP}.
  - Constant ARB_LATENCY = 2.
  - Function onehot_to_idx.
- Sub-module rr_picker (combinational): inputs REQ and pointer; outputs one-hot winner and its index. The REG_ARB_FIXED_PRIO_EN selection lives inside it.

Test Plan:
- Single write: REQ=01, WEN=1, ADDR=0x10, WDATA=0xDEADBEEF.
  - Expect REG_WEN=1 with ADDR 0x10 and WDATA 0xDEADBEEF at cycle+1.
  - Expect ACK=01 at cycle+2; RDATA unchanged.
- Single read: REQ=10, ADDR=0x04, bank returns 0x12345678.
  - Expect REG_REN pulse at cycle+1.
  - Expect ACK=10 with RDATA=0x12345678 at cycle+2.
- Contention: REQ=11 held for 4 passes from reset.
  - Expect grant order 0,1,0,1 and ACK every 3 cycles.
  - With REG_ARB_FIXED_PRIO_EN, expect 0,0,0,0.
- Wrap-around (NUM_REQ=4): pointer=3, REQ=0011 -> winner 0, pointer becomes 1.
- Early drop: REQ[1] deasserted in ACCESS -> ACK[1] still pulses and the bank strobe still occurs.
- Reset mid-op: RST asserted in ACCESS -> all outputs 0 immediately, no ACK. After release with REQ=01, a normal 3-cycle access completes.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-access arbiter.
//   arb_state_t   : access sequencer states (IDLE -> ACCESS -> RESP)
//   ARB_LATENCY   : cycles from the IDLE sample of REQ to the ACK pulse
//   MAX_REQ       : largest supported requester count
//   onehot_to_idx : converts a one-hot vector (up to MAX_REQ bits) to an index
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam int ARB_LATENCY = 2;
   localparam int MAX_REQ     = 8;

   // OR-reduction of set-bit positions; exact for one-hot input, 0 for all-zero.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for the register-access arbiter.
// Ports:
//   req_i     : per-requester request level
//   ptr_i     : round-robin start position (first requester searched)
//   win_oh_o  : one-hot winner, all-zero when nothing is requested
//   win_idx_o : index of the winner (0 when nothing is requested)
// Build option: REG_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, ptr_i ignored) instead of round-robin search from ptr_i.
module rr_picker
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [IDX_W-1:0]   win_idx_o
);

`ifdef REG_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   // Isolate the lowest set bit.
   assign win_oh_o = req_i & (~req_i + NUM_REQ'(1));
`else
   logic [IDX_W-1:0] pos;
   logic             found;

   // Walk the requesters starting at ptr_i, wrapping at NUM_REQ; first hit wins.
   always_comb begin
      win_oh_o = '0;
      found    = 1'b0;
      pos      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (!found && req_i[pos]) begin
            found         = 1'b1;
            win_oh_o[pos] = 1'b1;
         end
      end
   end
`endif

   assign win_idx_o = IDX_W'(onehot_to_idx(MAX_REQ'(win_oh_o)));

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one register-bank access port among NUM_REQ requesters.
// Each access runs IDLE (arbitrate + capture) -> ACCESS (one bank strobe)
// -> RESP (one-cycle ACK, read data returned) -> IDLE.
// Ports:
//   CLK, RST              : clock, asynchronous active-high reset
//   REQ, REQ_WEN          : per-requester request level and write(1)/read(0)
//   REQ_ADDR, REQ_WDATA   : packed per-requester address / write data
//   GNT                   : one-hot owner, held through ACCESS and RESP
//   ACK                   : one-hot completion pulse (RESP cycle)
//   RDATA                 : read data, valid in the ACK cycle, held until the next read ACK
//   REG_WEN, REG_REN      : bank strobes, only during ACCESS
//   REG_ADDR, REG_WDATA   : bank address / write data, hold last value
//   REG_RDATA             : bank read data, valid the cycle after REG_REN
//   DBG_STATE             : current sequencer state
// Handshake: a requester holds REQ/REQ_WEN/REQ_ADDR/REQ_WDATA until its ACK;
// everything is captured when REQ is sampled in IDLE, so later changes
// (including dropping REQ) do not affect the access in flight.
// Build option: REG_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority.
module reg_access_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ-1:0]            REQ_WEN,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
   output logic [NUM_REQ-1:0]            GNT,
   output logic [NUM_REQ-1:0]            ACK,
   output logic [DATA_WIDTH-1:0]         RDATA,
   output logic                          REG_WEN,
   output logic                          REG_REN,
   output logic [ADDR_WIDTH-1:0]         REG_ADDR,
   output logic [DATA_WIDTH-1:0]         REG_WDATA,
   input  logic [DATA_WIDTH-1:0]         REG_RDATA,
   output arb_state_t                    DBG_STATE
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t             state_q, state_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

   logic [NUM_REQ-1:0]     win_oh;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       rr_ptr;
   logic                   win_wen;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [DATA_WIDTH-1:0]  win_wdata;

`ifdef REG_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Pointer moves past the winner while its strobe is on the bank.
   assign ptr_d = (state_q != ACCESS)            ? ptr_q :
                  (idx_q == IDX_W'(NUM_REQ - 1)) ? '0    : idx_q + 1'b1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign rr_ptr = ptr_q;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i     (REQ),
      .ptr_i     (rr_ptr),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx)
   );

   // One-hot mux of the winner's request fields.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            win_addr  = win_addr  | REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = win_wdata | REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end
   assign win_wen = |(REQ_WEN & win_oh);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               gnt_d   = win_oh;
               idx_d   = win_idx;
               wen_d   = win_wen;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            if (!wen_q) rdata_d = REG_RDATA;
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign GNT       = gnt_q;
   assign ACK       = (state_q == RESP) ? gnt_q : '0;
   assign REG_WEN   = (state_q == ACCESS) &&  wen_q;
   assign REG_REN   = (state_q == ACCESS) && !wen_q;
   assign REG_ADDR  = addr_q;
   assign REG_WDATA = wdata_q;
   // Bank data arrives in the RESP cycle; pass it straight through so RDATA
   // is valid alongside ACK, and keep the registered copy afterwards.
   assign RDATA     = (state_q == RESP && !wen_q) ? REG_RDATA : rdata_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;
  import reg_arb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (2 requesters) ----------------
  logic [NR-1:0]    req, req_wen, gnt, ack;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rdata, reg_wdata, reg_rdata;
  logic             reg_wen, reg_ren;
  logic [AW-1:0]    reg_addr;
  arb_state_t       dbg_state;

  reg_access_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_WEN(req_wen), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .GNT(gnt), .ACK(ack), .RDATA(rdata),
    .REG_WEN(reg_wen), .REG_REN(reg_ren), .REG_ADDR(reg_addr),
    .REG_WDATA(reg_wdata), .REG_RDATA(reg_rdata), .DBG_STATE(dbg_state)
  );

  // ---------------- DUT (4 requesters, wrap-around) ----------------
  logic [3:0]    req4, req4_wen, gnt4, ack4;
  logic [4*AW-1:0] req4_addr;
  logic [4*DW-1:0] req4_wdata;
  logic [DW-1:0] rdata4, reg4_wdata, reg4_rdata;
  logic          reg4_wen, reg4_ren;
  logic [AW-1:0] reg4_addr;
  arb_state_t    dbg4_state;

  reg_access_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut4 (
    .CLK(clk), .RST(rst), .REQ(req4), .REQ_WEN(req4_wen), .REQ_ADDR(req4_addr),
    .REQ_WDATA(req4_wdata), .GNT(gnt4), .ACK(ack4), .RDATA(rdata4),
    .REG_WEN(reg4_wen), .REG_REN(reg4_ren), .REG_ADDR(reg4_addr),
    .REG_WDATA(reg4_wdata), .REG_RDATA(reg4_rdata), .DBG_STATE(dbg4_state)
  );

  // ---------------- register bank model behind DUT ----------------
  logic [DW-1:0] bank_mem  [256];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] model_rdata;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, ~b, b ^ 8'h5A, 8'h3C};
  endfunction

  always @(posedge clk) begin
    if (reg_wen) bank_mem[reg_addr] <= reg_wdata;
    if (reg_ren) reg_rdata <= bank_mem[reg_addr];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard: {ack one-hot, rdata} ----------------
  logic [NR+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [NR+DW-1:0] e;
    if (!rst && ack != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("ack_unexpected", 64'(ack), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ack_who", 64'(ack), 64'(e[NR+DW-1:DW]));
        check_eq("ack_rdata", 64'(rdata), 64'(e[DW-1:0]));
        check_eq("gnt_in_resp", 64'(gnt), 64'(e[NR+DW-1:DW]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Computes the expected outcome of one access and pushes it to the scoreboard.
  task automatic expect_access(input int who, input logic wen, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd);
    logic [NR-1:0] oh;
    oh = '0;
    oh[who] = 1'b1;
    if (wen) model_mem[addr] = wd;
    else     model_rdata     = model_mem[addr];
    exp_q.push_back({oh, model_rdata});
  endtask

  task automatic drive_req(input int who, input logic wen, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
    req[who]                 = 1'b1;
    req_wen[who]             = wen;
    req_addr[who*AW +: AW]   = addr;
    req_wdata[who*DW +: DW]  = wd;
  endtask

  task automatic do_access(input int who, input logic wen, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
    logic [NR-1:0] oh;
    oh = '0;
    oh[who] = 1'b1;
    @(negedge clk);
    req = '0;
    drive_req(who, wen, addr, wd);
    expect_access(who, wen, addr, wd);
    @(negedge clk);  // ACCESS
    check_eq("acc_state", 64'(dbg_state), 64'(ACCESS));
    check_eq("acc_wen", 64'(reg_wen), 64'(wen));
    check_eq("acc_ren", 64'(reg_ren), 64'(!wen));
    check_eq("acc_addr", 64'(reg_addr), 64'(addr));
    if (wen) check_eq("acc_wdata", 64'(reg_wdata), 64'(wd));
    check_eq("acc_gnt", 64'(gnt), 64'(oh));
    check_eq("acc_noack", 64'(ack), 64'd0);
    @(negedge clk);  // RESP: scoreboard checks ACK and RDATA
    check_eq("resp_strobes", 64'({reg_wen, reg_ren}), 64'd0);
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    req4 = '0;
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic acc4(input string tag, input logic [3:0] r, input logic [3:0] exp_g);
    @(negedge clk);
    req4 = r;
    @(negedge clk);
    check_eq({tag, "_gnt"}, 64'(gnt4), 64'(exp_g));
    check_eq({tag, "_wen"}, 64'(reg4_wen), 64'd1);
    @(negedge clk);
    check_eq({tag, "_ack"}, 64'(ack4), 64'(exp_g));
    req4 = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [NR-1:0] exp_oh [4];
    logic [3:0]    exp_w2;

    for (int i = 0; i < 256; i++) begin
      bank_mem[i]  = init_word(i);
      model_mem[i] = init_word(i);
    end
    bank_mem[8'h04]  = 32'h1234_5678;
    model_mem[8'h04] = 32'h1234_5678;
    rst = 1'b1;
    req = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    req4 = '0; req4_wen = 4'hF; req4_addr = '0; req4_wdata = '0;
    reg_rdata = '0; reg4_rdata = '0;
    model_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      req4_addr[i*AW +: AW]  = AW'(8'h80 + i);
      req4_wdata[i*DW +: DW] = DW'(32'hA000_0000 + i);
    end

    // reset state
    @(negedge clk);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    check_eq("rst_outs", 64'({gnt, ack, reg_wen, reg_ren}), 64'd0);
    check_eq("rst_addr_wdata", 64'({reg_addr, reg_wdata}), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;

    // single write then single read
    do_access(0, 1'b1, 8'h10, 32'hDEAD_BEEF);
    do_access(1, 1'b0, 8'h04, 32'h0);
    do_access(0, 1'b0, 8'h10, 32'h0);
    // write leaves RDATA unchanged
    do_access(1, 1'b1, 8'h22, 32'h0BAD_F00D);

    // random accesses
    for (int i = 0; i < 8; i++) begin
      do_access(int'($urandom_range(0, NR-1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 255)), $urandom);
    end

    // contention from reset: REQ=11 held for 4 passes
    do_reset();
`ifdef REG_ARB_FIXED_PRIO_EN
    exp_oh = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_oh = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    @(negedge clk);
    drive_req(0, 1'b0, 8'h20, 32'h0);
    drive_req(1, 1'b0, 8'h30, 32'h0);
    for (int p = 0; p < 4; p++) begin
      expect_access(exp_oh[p][1] ? 1 : 0, 1'b0, exp_oh[p][1] ? 8'h30 : 8'h20, 32'h0);
    end
    for (int p = 0; p < 4; p++) begin
      repeat ((p == 0) ? ARB_LATENCY : 3) @(negedge clk);
      check_eq("cont_ack_timing", 64'(ack), 64'(exp_oh[p]));
    end
    req = '0;

    // early drop: REQ[1] released during ACCESS
    @(negedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, 8'h08, 32'h0);
    expect_access(1, 1'b0, 8'h08, 32'h0);
    @(negedge clk);
    req = '0;
    check_eq("drop_ren", 64'(reg_ren), 64'd1);
    check_eq("drop_gnt", 64'(gnt), 64'b10);
    @(negedge clk);
    check_eq("drop_ack", 64'(ack), 64'b10);
    @(negedge clk);
    check_eq("drop_idle", 64'({dbg_state, gnt}), 64'({IDLE, 2'b00}));

    // reset during ACCESS: everything clears immediately, no ACK
    @(negedge clk);
    drive_req(0, 1'b1, 8'h40, 32'hCAFE_F00D);
    @(negedge clk);
    check_eq("mid_wen", 64'(reg_wen), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_state", 64'(dbg_state), 64'(IDLE));
    check_eq("mid_outs", 64'({gnt, ack, reg_wen, reg_ren}), 64'd0);
    check_eq("mid_addr_wdata", 64'({reg_addr, reg_wdata}), 64'd0);
    check_eq("mid_rdata", 64'(rdata), 64'd0);
    req = '0;
    model_rdata = '0;
    @(negedge clk);
    check_eq("mid_noack", 64'(ack), 64'd0);
    rst = 1'b0;
    do_access(0, 1'b1, 8'h44, 32'h5555_AAAA);
    do_access(0, 1'b0, 8'h44, 32'h0);

    // wrap-around on 4 requesters: pointer to 3, then REQ=0011
    acc4("w4_r2", 4'b0100, 4'b0100);
`ifdef REG_ARB_FIXED_PRIO_EN
    exp_w2 = 4'b0001;
`else
    exp_w2 = 4'b0010;
`endif
    acc4("w4_wrap", 4'b0011, 4'b0001);
    acc4("w4_next", 4'b0011, exp_w2);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
